data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- MEM-stage memory controller directly downstream of the Datapath's load/store signals; owns the data RAM port.
- Converts MemRead/MemWrite/Funct3 requests into accesses on a 128x32 synchronous single-port RAM with no byte enables.
- Does read-modify-write for SB/SH and sign/zero extension for LB/LH/LBU/LHU; stalls the pipeline until each access completes.

Parameters:
- DATA_W, 32, data word width (fixed at 32; other values unsupported).
- ADDR_W, 9, byte address width (512-byte data space).
- WADDR_W, 7, RAM word address width, = ADDR_W-2.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- MemRead  input  1  load request from MEM stage.
- MemWrite  input  1  store request from MEM stage.
- Funct3  input  3  access size/sign per RV32I encoding.
- addr  input  ADDR_W  byte address (ALU result bits [8:0]).
- wr_data  input  DATA_W  store data (rs2).
- rd_data  output  DATA_W  extended load result, valid in DONE.
- stall  output  1  hold IF/ID/EX/MEM stages this cycle.
- access_err  output  1  one-cycle pulse in DONE for misaligned or illegal Funct3.
- ram_addr  output  WADDR_W  RAM word address.
- ram_we  output  1  RAM write enable.
- ram_wdata  output  DATA_W  RAM write data.
- ram_rdata  input  DATA_W  RAM read data, valid one cycle after the address is presented with ram_we=0.
- tr_wr, tr_rd  output  1  trace pulses in DONE for a completed store/load.

Behaviour:
- Reset (async): state IDLE; rd_data, ram_addr, ram_wdata = 0; stall, ram_we, access_err, tr_wr, tr_rd = 0. Asserting reset mid-operation aborts the access: ram_we drops immediately and no partial write is issued afterwards.
- Request condition: req = MemRead | MemWrite. If both are set, MemWrite wins.
- stall = (state==IDLE & req) | (state not in {IDLE, DONE}). stall is low in DONE.
- In IDLE with req, latch addr, wr_data, Funct3 and the op, then classify the access:
  - Error: half access with addr[0]=1; word access with addr[1:0]!=0; load Funct3 in {3,6,7}; store Funct3 > 2.
  - On error: go to DONE next cycle with no RAM activity. In DONE: access_err=1, rd_data=0, tr_* = 0.
- Load (LB/LH/LW/LBU/LHU):
  - IDLE→RD: present ram_addr=addr_q[8:2], ram_we=0.
  - RD→RESP: ram_rdata is valid; extract the byte/half at addr_q[1:0], extend per Funct3, register into rd_data.
  - RESP→DONE: tr_rd=1.
  - Stall lasts 3 cycles.
- SW:
  - IDLE→WR: ram_we=1, ram_wdata=wr_data_q.
  - WR→DONE: tr_wr=1.
  - Stall lasts 2 cycles.
- SB/SH:
  - IDLE→RD: read the word.
  - RD→MERGE: ram_we=1, ram_wdata = ram_rdata with the byte/half lane at addr_q[1:0] replaced by wr_data_q[7:0] or wr_data_q[15:0].
  - MERGE→DONE: tr_wr=1.
  - Stall lasts 3 cycles.
- DONE→IDLE unconditionally. The request still visible in DONE is the one just completed and is never re-accepted.
- rd_data holds its value until the next load's RESP. Stores leave rd_data unchanged.
- Lane mapping is little-endian: byte k = bits [8k+7:8k]. Half at addr[1]=1 uses bits [31:16].
- ram_we is high only in WR and MERGE, for exactly one cycle per store.

Decomposition:
- Shared package riscv_mem_pkg:
  - Funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - State enum mem_state_t {IDLE, RD, RESP, WR, MERGE, DONE}.
  - Widths ADDR_W/WADDR_W.
- One combinational sub-module, ls_align: inputs word, byte offset, Funct3, store data; outputs the extended load value and the merged store word. It is shared by the RESP and MERGE paths.

Test Plan:
- RAM[5]=0x8899AABB; LB at addr 0x015 → stall high 3 cycles, DONE rd_data=0xFFFFFFAA, tr_rd=1.
- Same word; LHU at 0x016 → rd_data=0x00008899. LH at 0x016 → rd_data=0xFFFF8899.
- RAM[2]=0x11223344; SB 0xCC at 0x00A → one-cycle ram_we with ram_wdata=0x11CC3344. A following LW of 0x008 returns 0x11CC3344.
- SW 0xDEADBEEF at 0x1FC → stall 2 cycles, ram_addr=127, ram_wdata=0xDEADBEEF. LW of 0x1FC then returns the same value (wrap boundary).
- LW at 0x006, then SH at 0x003 → each stalls 1 cycle with access_err=1, ram_we never high, rd_data=0.
- SH issued, reset asserted in the RD cycle → all outputs 0 immediately, no write; after release, LW of that word shows the original contents.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory controller:
// RV32I load/store Funct3 codes, controller states and address widths.
package riscv_mem_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int WADDR_W = ADDR_W - 2;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {IDLE, RD, RESP, WR, MERGE, DONE} mem_state_t;

    // Misaligned halves/words and unused Funct3 encodings are rejected before touching RAM.
    function automatic logic access_illegal(input logic is_store, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic bad;
        if (is_store) bad = (f3 > F3_SW);
        else          bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        case (f3[1:0])
            2'd1:    bad = bad | off[0];
            2'd2:    bad = bad | (off != 2'd0);
            default: bad = bad;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Port bundle between the memory controller and the 128x32 single-port data RAM.
interface data_mem_ctrl_if;
    import riscv_mem_pkg::*;

    logic [WADDR_W-1:0] ram_addr;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    modport master (output ram_addr, output ram_we, output ram_wdata, input ram_rdata);
    modport slave  (input ram_addr, input ram_we, input ram_wdata, output ram_rdata);

endinterface

// File: rtl/data_mem_ctrl_ls_align.sv
// Lane steering for sub-word accesses: extends a loaded byte/half and
// merges store data into a read word (little-endian lanes).
module ls_align
    import riscv_mem_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] ld_val,
    output logic [DATA_W-1:0] st_word
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = word[{off, 3'b000} +: 8];
        half_s = off[1] ? word[31:16] : word[15:0];

        ld_val = '0;
        case (funct3)
            F3_LB:   ld_val = DATA_W'(byte_s);
            F3_LH:   ld_val = DATA_W'(half_s);
            F3_LW:   ld_val = word;
            F3_LBU:  ld_val = DATA_W'($unsigned(byte_s));
            F3_LHU:  ld_val = DATA_W'($unsigned(half_s));
            default: ld_val = '0;
        endcase

        st_word = word;
        case (funct3)
            F3_SB: st_word[{off, 3'b000} +: 8] = st_data[7:0];
            F3_SH: begin
                if (off[1]) st_word[31:16] = st_data[15:0];
                else        st_word[15:0]  = st_data[15:0];
            end
            F3_SW:   st_word = st_data;
            default: st_word = word;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: turns load/store requests into accesses on a
// 128x32 synchronous RAM without byte enables, stalling the pipeline until done.
module data_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int WADDR_W = ADDR_W - 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic              access_err,
    output logic              tr_wr,
    output logic              tr_rd,
    data_mem_ctrl_if.master   ram
);

    mem_state_t         state_q, state_d;
    logic               is_store_q, is_store_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         off_q, off_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [WADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic               ram_we_q, ram_we_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic               access_err_q, access_err_d;
    logic               tr_wr_q, tr_wr_d;
    logic               tr_rd_q, tr_rd_d;

    logic               req;
    logic [DATA_W-1:0]  ld_val;
    logic [DATA_W-1:0]  st_word;

    assign req = MemRead | MemWrite;

    ls_align u_align (
        .word    (ram.ram_rdata),
        .off     (off_q),
        .funct3  (f3_q),
        .st_data (wdata_q),
        .ld_val  (ld_val),
        .st_word (st_word)
    );

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        f3_d         = f3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;
        access_err_d = 1'b0;
        tr_wr_d      = 1'b0;
        tr_rd_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    is_store_d = MemWrite;
                    f3_d       = Funct3;
                    off_d      = addr[1:0];
                    wdata_d    = wr_data;
                    if (access_illegal(MemWrite, Funct3, addr[1:0])) begin
                        state_d      = DONE;
                        access_err_d = 1'b1;
                        rd_data_d    = '0;
                    end else if (MemWrite && (Funct3 == F3_SW)) begin
                        state_d     = WR;
                        ram_addr_d  = addr[ADDR_W-1:2];
                        ram_we_d    = 1'b1;
                        ram_wdata_d = wr_data;
                    end else begin
                        state_d    = RD;
                        ram_addr_d = addr[ADDR_W-1:2];
                    end
                end
            end
            RD: begin
                // Sub-word stores write back during MERGE once the read word is on ram_rdata.
                if (is_store_q) begin
                    state_d  = MERGE;
                    ram_we_d = 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d   = DONE;
                rd_data_d = ld_val;
                tr_rd_d   = 1'b1;
            end
            WR: begin
                state_d = DONE;
                tr_wr_d = 1'b1;
            end
            MERGE: begin
                state_d     = DONE;
                ram_wdata_d = st_word;
                tr_wr_d     = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            access_err_q <= 1'b0;
            tr_wr_q      <= 1'b0;
            tr_rd_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            access_err_q <= access_err_d;
            tr_wr_q      <= tr_wr_d;
            tr_rd_q      <= tr_rd_d;
        end
    end

    assign stall = ~reset & (((state_q == IDLE) & req) |
                             ((state_q != IDLE) & (state_q != DONE)));

    assign rd_data       = rd_data_q;
    assign access_err    = access_err_q;
    assign tr_wr         = tr_wr_q;
    assign tr_rd         = tr_rd_q;
    assign ram.ram_addr  = ram_addr_q;
    assign ram.ram_we    = ram_we_q;
    assign ram.ram_wdata = (state_q == MERGE) ? st_word : ram_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with a behavioural 128x32 synchronous RAM.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        stall, access_err, tr_wr, tr_rd;

    data_mem_ctrl_if ram_if ();

    data_mem_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .stall      (stall),
        .access_err (access_err),
        .tr_wr      (tr_wr),
        .tr_rd      (tr_rd),
        .ram        (ram_if)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [128];
    logic [31:0] rdata_r = 32'h0;
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[2]  <= 32'h11223344;
            mem[5]  <= 32'h8899AABB;
            mem[10] <= 32'h55667788;
        end else if (ram_if.ram_we) begin
            mem[ram_if.ram_addr] <= ram_if.ram_wdata;
        end else begin
            rdata_r <= mem[ram_if.ram_addr];
        end
    end
    assign ram_if.ram_rdata = rdata_r;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic        trw;
        logic        trr;
    } exp_t;

    typedef struct packed {
        logic [6:0]  wa;
        logic [31:0] wd;
    } wexp_t;

    exp_t  sb_q [$];
    wexp_t wr_q [$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: every DONE pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (!reset && (tr_rd || tr_wr || access_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {29'd0, access_err, tr_wr, tr_rd}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rd_data",    rd_data,    e.rd);
                chk("access_err", {31'd0, access_err}, {31'd0, e.err});
                chk("tr_wr",      {31'd0, tr_wr},      {31'd0, e.trw});
                chk("tr_rd",      {31'd0, tr_rd},      {31'd0, e.trr});
            end
        end
    end

    // Write monitor: each ram_we cycle must match one expected store.
    always @(negedge clk) begin
        if (!reset && ram_if.ram_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_we", {25'd0, ram_if.ram_addr}, 32'hFFFFFFFF);
            end else begin
                wexp_t w;
                w = wr_q.pop_front();
                chk("ram_addr",  {25'd0, ram_if.ram_addr}, {25'd0, w.wa});
                chk("ram_wdata", ram_if.ram_wdata, w.wd);
            end
        end
    end

    task automatic issue(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] d, input int exp_stall);
        int n;
        MemRead  = rd;
        MemWrite = wr;
        Funct3   = f3;
        addr     = a;
        wr_data  = d;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stall) n++;
            else break;
        end
        chk({nm, "_stall"}, n, exp_stall);
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic exp_resp(input logic [31:0] rd, input logic err, input logic trw, input logic trr);
        exp_t e;
        e.rd = rd; e.err = err; e.trw = trw; e.trr = trr;
        sb_q.push_back(e);
    endtask

    task automatic exp_write(input logic [6:0] wa, input logic [31:0] wd);
        wexp_t w;
        w.wa = wa; w.wd = wd;
        wr_q.push_back(w);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_stall"},      {31'd0, stall},           32'd0);
        chk({nm, "_ram_we"},     {31'd0, ram_if.ram_we},   32'd0);
        chk({nm, "_ram_addr"},   {25'd0, ram_if.ram_addr}, 32'd0);
        chk({nm, "_ram_wdata"},  ram_if.ram_wdata,         32'd0);
        chk({nm, "_rd_data"},    rd_data,                  32'd0);
        chk({nm, "_access_err"}, {31'd0, access_err},      32'd0);
        chk({nm, "_tr"},         {30'd0, tr_wr, tr_rd},    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; preload = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0; addr = 9'd0; wr_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        preload = 1'b0;
        reset   = 1'b0;

        exp_resp(32'hFFFFFFAA, 1'b0, 1'b0, 1'b1);
        issue("lb_015", 1'b1, 1'b0, 3'd0, 9'h015, 32'h0, 3);
        exp_resp(32'h00008899, 1'b0, 1'b0, 1'b1);
        issue("lhu_016", 1'b1, 1'b0, 3'd5, 9'h016, 32'h0, 3);
        exp_resp(32'hFFFF8899, 1'b0, 1'b0, 1'b1);
        issue("lh_016", 1'b1, 1'b0, 3'd1, 9'h016, 32'h0, 3);

        exp_write(7'd2, 32'h11CC3344);
        exp_resp(32'hFFFF8899, 1'b0, 1'b1, 1'b0);
        issue("sb_00a", 1'b0, 1'b1, 3'd0, 9'h00A, 32'hFFFFFFCC, 3);
        exp_resp(32'h11CC3344, 1'b0, 1'b0, 1'b1);
        issue("lw_008", 1'b1, 1'b0, 3'd2, 9'h008, 32'h0, 3);

        exp_write(7'd127, 32'hDEADBEEF);
        exp_resp(32'h11CC3344, 1'b0, 1'b1, 1'b0);
        issue("sw_1fc", 1'b0, 1'b1, 3'd2, 9'h1FC, 32'hDEADBEEF, 2);
        exp_resp(32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
        issue("lw_1fc", 1'b1, 1'b0, 3'd2, 9'h1FC, 32'h0, 3);

        exp_resp(32'h00000088, 1'b0, 1'b0, 1'b1);
        issue("lbu_017", 1'b1, 1'b0, 3'd4, 9'h017, 32'h0, 3);
        exp_resp(32'hFFFFFFBB, 1'b0, 1'b0, 1'b1);
        issue("lb_014", 1'b1, 1'b0, 3'd0, 9'h014, 32'h0, 3);

        // SH to word 10, aborted by reset while the read is in flight.
        MemWrite = 1'b1; Funct3 = 3'd1; addr = 9'h028; wr_data = 32'h0000ABCD;
        @(posedge clk);
        #1;
        chk("sh_abort_in_rd", {31'd0, stall}, 32'd1);
        reset = 1'b1; MemWrite = 1'b0;
        #1;
        chk_outputs_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_resp(32'h55667788, 1'b0, 1'b0, 1'b1);
        issue("lw_028", 1'b1, 1'b0, 3'd2, 9'h028, 32'h0, 3);

        exp_resp(32'h0, 1'b1, 1'b0, 1'b0);
        issue("lw_006_err", 1'b1, 1'b0, 3'd2, 9'h006, 32'h0, 1);
        exp_resp(32'h0, 1'b1, 1'b0, 1'b0);
        issue("sh_003_err", 1'b0, 1'b1, 3'd1, 9'h003, 32'h1234, 1);
        exp_resp(32'h0, 1'b1, 1'b0, 1'b0);
        issue("ld_f3_3_err", 1'b1, 1'b0, 3'd3, 9'h000, 32'h0, 1);
        exp_resp(32'h0, 1'b1, 1'b0, 1'b0);
        issue("st_f3_4_err", 1'b0, 1'b1, 3'd4, 9'h000, 32'h0, 1);

        exp_write(7'd3, 32'h12345678);
        exp_resp(32'h0, 1'b0, 1'b1, 1'b0);
        issue("both_sw_00c", 1'b1, 1'b1, 3'd2, 9'h00C, 32'h12345678, 2);
        exp_write(7'd5, 32'hBEEFAABB);
        exp_resp(32'h0, 1'b0, 1'b1, 1'b0);
        issue("sh_016", 1'b0, 1'b1, 3'd1, 9'h016, 32'h0000BEEF, 3);
        exp_resp(32'h12345678, 1'b0, 1'b0, 1'b1);
        issue("lw_00c", 1'b1, 1'b0, 3'd2, 9'h00C, 32'h0, 3);
        exp_resp(32'hBEEFAABB, 1'b0, 1'b0, 1'b1);
        issue("lw_014", 1'b1, 1'b0, 3'd2, 9'h014, 32'h0, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("resp_queue_drained", sb_q.size(), 32'd0);
        chk("write_queue_drained", wr_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
